// File: rtl/bpm_beat_tracker_pkg.sv
// Shared types and constants for the BPM beat tracker: lock states, Q-format
// of the smoothed tempo, and the phase increment per BPM.
package bpm_beat_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int FRAC_BITS = 8;

  // round(2^phase_w / (60 * clk_hz)): phase advance per cycle for 1 BPM
  function automatic logic [63:0] inc_per_bpm(input int clk_hz, input int phase_w);
    logic [63:0] den;
    den = 64'(60) * 64'(clk_hz);
    return ((64'd1 << phase_w) + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/bpm_beat_tracker_phase_acc.sv
// Tempo phase accumulator: one wrap per beat, onset resync while locked,
// registered beat tick, beat phase and 4/4 beat index.
module bpm_beat_tracker_phase_acc
  import bpm_beat_tracker_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PHASE_W = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        locked_i,
  input  logic        onset_i,
  input  logic [15:0] bpm_i,
  output logic        tick_o,
  output logic [7:0]  phase_o,
  output logic [1:0]  count_o
);

  localparam logic [PHASE_W-1:0] INC_PER_BPM = PHASE_W'(inc_per_bpm(CLK_HZ, PHASE_W));

  logic [PHASE_W-1:0] acc_q, acc_d, inc_q;
  logic [PHASE_W:0]   sum;
  logic [7:0]         phase;
  logic               tick_q, tick_d;
  logic [1:0]         count_q;
  logic               early, late, resync;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    phase  = acc_q[PHASE_W-1 -: 8];
    early  = phase >= 8'hC0;
    late   = phase < 8'h40;
    // a wrap coinciding with an onset still yields one tick and a clean restart
    resync = locked_i && onset_i && (early || late || sum[PHASE_W]);
    tick_d = 1'b0;
    acc_d  = '0;
    if (run_i) begin
      tick_d = sum[PHASE_W] || (locked_i && onset_i && early);
      acc_d  = resync ? '0 : sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      inc_q   <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= {{(PHASE_W-16){1'b0}}, bpm_i} * INC_PER_BPM;
      tick_q  <= tick_d;
      count_q <= count_q + {1'b0, tick_d};
    end
  end

  assign tick_o  = tick_q;
  assign phase_o = phase;
  assign count_o = count_q;

endmodule

// File: rtl/bpm_beat_tracker.sv
// Filters raw BPM estimates (range check + EMA), tracks lock, and drives the
// beat phase accumulator that produces the metronome-stable beat tick.
//   state   | meaning
//   IDLE    | no accepted estimate since reset, accumulator held at 0
//   ACQUIRE | counting consecutive agreeing estimates toward lock
//   LOCKED  | tempo trusted, onsets resync the beat phase
module bpm_beat_tracker
  import bpm_beat_tracker_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BPM_MIN    = 60,
  parameter int BPM_MAX    = 200,
  parameter int EMA_SHIFT  = 2,
  parameter int TOL_BPM    = 6,
  parameter int LOCK_COUNT = 4,
  parameter int PHASE_W    = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bpm_in,
  input  logic        bpm_valid,
  input  logic        onset_pulse,
  output logic [15:0] bpm_out,
  output logic        bpm_locked,
  output logic        beat_tick,
  output logic [7:0]  beat_phase,
  output logic [1:0]  beat_count,
  output logic [7:0]  reject_cnt
);

  state_e              state_q, state_d;
  logic [23:0]         bpm_s_q, bpm_s_d;
  logic [15:0]         bpm_out_q;
  logic [7:0]          agree_q, agree_d, miss_q, miss_d;
  logic [7:0]          reject_q, reject_d;
  logic                locked_q;
  logic                in_range, accept, agree;
  logic [16:0]         diff_bpm, abs_bpm;
  logic [23:0]         load_s, ema_s;
  logic signed [24:0]  ema_diff;

  always_comb begin
    in_range = (bpm_in >= 16'(BPM_MIN)) && (bpm_in <= 16'(BPM_MAX));
    accept   = bpm_valid && in_range;
    diff_bpm = {1'b0, bpm_in} - {1'b0, bpm_out_q};
    abs_bpm  = diff_bpm[16] ? -diff_bpm : diff_bpm;
    agree    = abs_bpm <= 17'(TOL_BPM);
    load_s   = 24'(bpm_in) << FRAC_BITS;
    ema_diff = $signed({1'b0, load_s}) - $signed({1'b0, bpm_s_q});
    ema_s    = bpm_s_q + 24'(ema_diff >>> EMA_SHIFT);
    reject_d = (bpm_valid && !in_range && reject_q != 8'hFF) ? reject_q + 8'd1 : reject_q;
  end

  always_comb begin
    state_d = state_q;
    bpm_s_d = bpm_s_q;
    agree_d = agree_q;
    miss_d  = miss_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          bpm_s_d = load_s;
          agree_d = '0;
          miss_d  = '0;
        end
        ACQUIRE: begin
          if (agree) begin
            bpm_s_d = ema_s;
            if (agree_q + 8'd1 == 8'(LOCK_COUNT)) begin
              state_d = LOCKED;
              agree_d = '0;
              miss_d  = '0;
            end else begin
              agree_d = agree_q + 8'd1;
            end
          end else begin
            agree_d = '0;
            bpm_s_d = load_s;
          end
        end
        LOCKED: begin
          if (agree) begin
            miss_d  = '0;
            bpm_s_d = ema_s;
          end else if (miss_q + 8'd1 == 8'(LOCK_COUNT)) begin
            state_d = ACQUIRE;
            miss_d  = '0;
            agree_d = '0;
            bpm_s_d = load_s;
          end else begin
            miss_d  = miss_q + 8'd1;
            bpm_s_d = ema_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bpm_s_q   <= '0;
      bpm_out_q <= '0;
      agree_q   <= '0;
      miss_q    <= '0;
      reject_q  <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bpm_s_q   <= bpm_s_d;
      bpm_out_q <= 16'((bpm_s_d + 24'h80) >> FRAC_BITS);
      agree_q   <= agree_d;
      miss_q    <= miss_d;
      reject_q  <= reject_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  bpm_beat_tracker_phase_acc #(
    .CLK_HZ (CLK_HZ),
    .PHASE_W(PHASE_W)
  ) u_phase_acc (
    .clk_i   (clk),
    .rst_ni  (reset),
    .run_i   (state_q != IDLE),
    .locked_i(state_q == LOCKED),
    .onset_i (onset_pulse),
    .bpm_i   (bpm_out_q),
    .tick_o  (beat_tick),
    .phase_o (beat_phase),
    .count_o (beat_count)
  );

  assign bpm_out    = bpm_out_q;
  assign bpm_locked = locked_q;
  assign reject_cnt = reject_q;

endmodule
